// File: rtl/uxn_screen_port_if.sv
// CPU-side device port and draw-queue output bundle for uxn_screen_port.
interface uxn_screen_port_if;
  logic        port_wr_en;
  logic [3:0]  port_addr;
  logic [7:0]  port_wr_data;
  logic [7:0]  port_rd_data;
  logic [23:0] data;
  logic        we;
  logic        busy;

  // CPU / bench side: drives writes, observes reads and queue output
  modport master (
    output port_wr_en, port_addr, port_wr_data,
    input  port_rd_data, data, we, busy
  );

  // Screen port side
  modport slave (
    input  port_wr_en, port_addr, port_wr_data,
    output port_rd_data, data, we, busy
  );
endinterface

// File: rtl/uxn_screen_port.sv
// uxn_screen_port: Varvara screen device register file and draw-queue feeder.
// Decodes writes to ports 0x2_ (low nibble), keeps x/y/addr/auto, and turns
// pixel and sprite writes into 24-bit queue words, expanding auto-repeat runs.
// Optional feature macro: SCREEN_AUTO_REPEAT_EN (honour the auto length nibble).
module uxn_screen_port #(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 288
) (
  input  logic               clk,
  input  logic               rst_n,
  uxn_screen_port_if.slave   bus
);

  localparam int unsigned XY_W   = 16;
  localparam int unsigned WORD_W = 24;
  localparam int unsigned LEN_W  = 4;

  localparam logic [XY_W-1:0] W_LIM = XY_W'(SCREEN_W);
  localparam logic [XY_W-1:0] H_LIM = XY_W'(SCREEN_H);
  localparam logic [XY_W-1:0] W_MAX = XY_W'(SCREEN_W - 1);
  localparam logic [XY_W-1:0] H_MAX = XY_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, PIX, SPR0, SPR1} state_t;

  state_t              state_q, state_d;
  logic [XY_W-1:0]     x_q, x_d, y_q, y_d, addr_q, addr_d;
  logic [7:0]          auto_q, auto_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic [XY_W-1:0]     cur_x_q, cur_x_d, cur_y_q, cur_y_d, cur_addr_q, cur_addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                we_q, we_d, busy_q, busy_d;
  logic [7:0]          rd_q, rd_d;

  logic [XY_W-1:0]     dx_c, dy_c, step_c;
  logic [XY_W-1:0]     x_clamp_c, y_clamp_c;
  logic [LEN_W-1:0]    run_len_c;

  // Repeat count of a sprite run (length nibble, or single sprite)
`ifdef SCREEN_AUTO_REPEAT_EN
  assign run_len_c = auto_q[7:4];
`else
  assign run_len_c = LEN_W'(0);
`endif

  // Per-sprite deltas of the run in progress; auto and cmd are frozen while busy
  assign dx_c   = auto_q[0] ? (cmd_q[4] ? 16'hFFF8 : 16'h0008) : 16'h0000;
  assign dy_c   = auto_q[1] ? (cmd_q[5] ? 16'hFFF8 : 16'h0008) : 16'h0000;
  assign step_c = auto_q[2] ? (cmd_q[7] ? 16'h0010 : 16'h0008) : 16'h0000;

  // Fill origin is pulled back onto the screen
  assign x_clamp_c = (x_q >= W_LIM) ? W_MAX : x_q;
  assign y_clamp_c = (y_q >= H_LIM) ? H_MAX : y_q;

  // State, register file and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      auto_q     <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      cur_addr_q <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      auto_q     <= auto_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      cur_addr_q <= cur_addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      rd_q       <= rd_d;
    end
  end

  // Next-state, register updates and queue word generation
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    auto_d     = auto_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    cur_addr_d = cur_addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    busy_d     = 1'b0;
    rd_d       = 8'h00;

    case (bus.port_addr)
      4'h6:    rd_d = auto_q;
      4'h8:    rd_d = x_q[15:8];
      4'h9:    rd_d = x_q[7:0];
      4'hA:    rd_d = y_q[15:8];
      4'hB:    rd_d = y_q[7:0];
      4'hC:    rd_d = addr_q[15:8];
      4'hD:    rd_d = addr_q[7:0];
      default: rd_d = 8'h00;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.port_wr_en) begin
          case (bus.port_addr)
            4'h6: auto_d = bus.port_wr_data;
            4'h8: x_d    = {bus.port_wr_data, x_q[7:0]};
            4'h9: x_d    = {x_q[15:8], bus.port_wr_data};
            4'hA: y_d    = {bus.port_wr_data, y_q[7:0]};
            4'hB: y_d    = {y_q[15:8], bus.port_wr_data};
            4'hC: addr_d = {bus.port_wr_data, addr_q[7:0]};
            4'hD: addr_d = {addr_q[15:8], bus.port_wr_data};
            4'hE: begin
              state_d = PIX;
              cmd_d   = bus.port_wr_data;
              busy_d  = 1'b1;
              if (bus.port_wr_data[7]) begin
                we_d   = 1'b1;
                data_d = {bus.port_wr_data[6], bus.port_wr_data[1:0], 1'b1,
                          bus.port_wr_data[5], bus.port_wr_data[4],
                          x_clamp_c[8:0], y_clamp_c[8:0]};
              end else if ((x_q < W_LIM) && (y_q < H_LIM)) begin
                we_d   = 1'b1;
                data_d = {bus.port_wr_data[6], bus.port_wr_data[1:0], 3'b000,
                          x_q[8:0], y_q[8:0]};
              end
            end
            4'hF: begin
              state_d    = SPR0;
              cmd_d      = bus.port_wr_data;
              len_d      = run_len_c;
              cnt_d      = '0;
              cur_x_d    = x_q;
              cur_y_d    = y_q;
              cur_addr_d = addr_q;
              busy_d     = 1'b1;
              we_d       = 1'b1;
              data_d     = {bus.port_wr_data[6], bus.port_wr_data[1:0], 1'b0, 1'b1,
                            bus.port_wr_data[7], x_q[8:0], y_q[8:0]};
            end
            default: ;
          endcase
        end
      end

      PIX: begin
        state_d = IDLE;
        if (!cmd_q[7]) begin
          x_d = x_q + XY_W'(auto_q[0]);
          y_d = y_q + XY_W'(auto_q[1]);
        end
      end

      SPR0: begin
        state_d = SPR1;
        busy_d  = 1'b1;
        we_d    = 1'b1;
        data_d  = {4'h0, cmd_q[5], cmd_q[4], cmd_q[3:2], cur_addr_q};
      end

      SPR1: begin
        if (cnt_q == len_q) begin
          state_d = IDLE;
          x_d     = x_q + dx_c;
          y_d     = y_q + dy_c;
          addr_d  = cur_addr_q + step_c;
        end else begin
          // Sprite i sits at (x + i*DY, y + i*DX)
          state_d    = SPR0;
          cnt_d      = cnt_q + LEN_W'(1);
          cur_x_d    = cur_x_q + dy_c;
          cur_y_d    = cur_y_q + dx_c;
          cur_addr_d = cur_addr_q + step_c;
          busy_d     = 1'b1;
          we_d       = 1'b1;
          data_d     = {cmd_q[6], cmd_q[1:0], 1'b0, 1'b1, cmd_q[7],
                        cur_x_d[8:0], cur_y_d[8:0]};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.port_rd_data = rd_q;
  assign bus.data         = data_q;
  assign bus.we           = we_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uxn_screen_port.sv
// Randomized self-checking bench for uxn_screen_port against a behavioural model.
module tb_uxn_screen_port;

  localparam int SW = 320;
  localparam int SH = 288;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uxn_screen_port_if bus();

  uxn_screen_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic [23:0] got_w[$];
  int          got_t[$];

  // Reference model state
  bit [15:0]   m_x, m_y, m_addr;
  bit [7:0]    m_auto;
  logic [23:0] exp_w[$];
  int          exp_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue-side monitor: capture every emitted word and count busy cycles
  always @(negedge clk) begin
    if (bus.we) begin
      got_w.push_back(bus.data);
      got_t.push_back(cyc);
    end
    if (bus.busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pack0(int layer, int color, int b20, int b19, int b18,
                                        int px, int py);
    return 24'(layer * (1 << 23) + color * (1 << 21) + b20 * (1 << 20) + b19 * (1 << 19)
               + b18 * (1 << 18) + (px % 512) * 512 + (py % 512));
  endfunction

  function automatic logic [23:0] pack1(int fy, int fx, int chi, int a);
    return 24'(fy * (1 << 19) + fx * (1 << 18) + chi * (1 << 16) + a);
  endfunction

  function automatic logic [23:0] got_at(int i);
    return (i < got_w.size()) ? got_w[i] : 24'hxxxxxx;
  endfunction

  // Behavioural effect of one port write: register update and expected words
  task automatic model_cmd(input logic [3:0] a, input logic [7:0] d);
    int px, py, fill, L, dx, dy, s, xi, yi, ai;
    exp_w.delete();
    exp_busy = 0;
    case (a)
      4'h6: m_auto = d;
      4'h8: m_x[15:8] = d;
      4'h9: m_x[7:0] = d;
      4'hA: m_y[15:8] = d;
      4'hB: m_y[7:0] = d;
      4'hC: m_addr[15:8] = d;
      4'hD: m_addr[7:0] = d;
      4'hE: begin
        exp_busy = 1;
        fill = int'(d[7]);
        px = int'(m_x);
        py = int'(m_y);
        if (fill == 1) begin
          if (px > SW - 1) px = SW - 1;
          if (py > SH - 1) py = SH - 1;
          exp_w.push_back(pack0(int'(d[6]), int'(d[1:0]), 1, int'(d[5]), int'(d[4]), px, py));
        end else begin
          if (px < SW && py < SH)
            exp_w.push_back(pack0(int'(d[6]), int'(d[1:0]), 0, 0, 0, px, py));
          m_x = 16'(int'(m_x) + int'(m_auto[0]));
          m_y = 16'(int'(m_y) + int'(m_auto[1]));
        end
      end
      4'hF: begin
`ifdef SCREEN_AUTO_REPEAT_EN
        L = int'(m_auto[7:4]);
`else
        L = 0;
`endif
        dx = m_auto[0] ? (d[4] ? -8 : 8) : 0;
        dy = m_auto[1] ? (d[5] ? -8 : 8) : 0;
        s  = m_auto[2] ? (d[7] ? 16 : 8) : 0;
        for (int i = 0; i <= L; i++) begin
          xi = (int'(m_x) + i * dy) & 32'hFFFF;
          yi = (int'(m_y) + i * dx) & 32'hFFFF;
          ai = (int'(m_addr) + i * s) & 32'hFFFF;
          exp_w.push_back(pack0(int'(d[6]), int'(d[1:0]), 0, 1, int'(d[7]), xi, yi));
          exp_w.push_back(pack1(int'(d[5]), int'(d[4]), int'(d[3:2]), ai));
        end
        exp_busy = 2 * (L + 1);
        m_x    = 16'(int'(m_x) + dx);
        m_y    = 16'(int'(m_y) + dy);
        m_addr = 16'(int'(m_addr) + (L + 1) * s);
      end
      default: ;
    endcase
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.port_wr_en   = 1'b1;
    bus.port_addr    = a;
    bus.port_wr_data = d;
    @(negedge clk);
    bus.port_wr_en   = 1'b0;
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
    model_cmd(a, d);
    wr(a, d);
  endtask

  task automatic set16(input logic [3:0] a, input logic [15:0] v);
    set_reg(a, v[15:8]);
    set_reg(a + 4'h1, v[7:0]);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.port_addr = a;
    @(negedge clk);
    d = bus.port_rd_data;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] hi, lo;
    rd(4'h8, hi); rd(4'h9, lo); check({tag, "_x"}, {hi, lo}, m_x);
    rd(4'hA, hi); rd(4'hB, lo); check({tag, "_y"}, {hi, lo}, m_y);
    rd(4'hC, hi); rd(4'hD, lo); check({tag, "_addr"}, {hi, lo}, m_addr);
    rd(4'h6, hi); check({tag, "_auto"}, hi, m_auto);
  endtask

  // Issue a pixel/sprite write, optionally poke x while busy, and score the output
  task automatic run_cmd(input string tag, input logic [3:0] a, input logic [7:0] d,
                         input bit intrude);
    int wc, n, k;
    model_cmd(a, d);
    got_w.delete();
    got_t.delete();
    busy_cnt = 0;
    wc = cyc;
    wr(a, d);
    if (intrude) wr(4'h8, 8'hFF);
    n = 0;
    while (bus.busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_bound"}, 32'(n < 64), 32'd1);
    @(negedge clk);
    check({tag, "_nwords"}, got_w.size(), exp_w.size());
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    k = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < k; i++) begin
      check({tag, "_word"}, got_w[i], exp_w[i]);
      check({tag, "_word_cycle"}, got_t[i], wc + 1 + i);
    end
    if (exp_w.size() > 0) check({tag, "_data_hold"}, bus.data, exp_w[exp_w.size() - 1]);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] xr, yr;
    logic [3:0]  ca;
    bus.port_wr_en   = 1'b0;
    bus.port_addr    = 4'h0;
    bus.port_wr_data = 8'h00;
    rst_n  = 1'b0;
    m_x = '0; m_y = '0; m_addr = '0; m_auto = '0;
    repeat (2) @(negedge clk);
    check("rst_we", bus.we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_data", bus.data, 0);
    check("rst_rd", bus.port_rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_regs("rst");

    // Plain pixel on layer 1
    set16(4'h8, 16'h0010);
    set16(4'hA, 16'h0020);
    run_cmd("tp_pix", 4'hE, 8'h41, 1'b0);
    check("tp_pix_const", got_at(0), 24'hA02020);

    // Fill pixel: x/y not advanced
    set16(4'h8, 16'd100);
    set16(4'hA, 16'd50);
    run_cmd("tp_fill", 4'hE, 8'h93, 1'b0);
    check("tp_fill_const", got_at(0), 24'h74C832);
    check_regs("tp_fill");

    // Single 2bpp sprite
    set16(4'h8, 16'd8);
    set16(4'hA, 16'd0);
    set16(4'hC, 16'h1234);
    run_cmd("tp_spr", 4'hF, 8'h85, 1'b0);
    check("tp_spr_w0", got_at(0), 24'h2C1000);
    check("tp_spr_w1", got_at(1), 24'h011234);

    // Auto-repeat run
    set_reg(4'h6, 8'h15);
    set16(4'h8, 16'd0);
    set16(4'hA, 16'd0);
    set16(4'hC, 16'h0100);
    run_cmd("tp_auto", 4'hF, 8'h01, 1'b0);
    check("tp_auto_w0", got_at(0), 24'h280000);
    check("tp_auto_w1", got_at(1), 24'h000100);
`ifdef SCREEN_AUTO_REPEAT_EN
    check("tp_auto_w2", got_at(2), 24'h280008);
    check("tp_auto_w3", got_at(3), 24'h000108);
`endif
    check_regs("tp_auto");

    // Off-screen plain pixel and writes while busy
    set16(4'h8, 16'd400);
    run_cmd("tp_drop", 4'hE, 8'h01, 1'b1);
    check("tp_drop_none", got_w.size(), 0);
    check_regs("tp_drop");
    run_cmd("tp_busywr", 4'hF, 8'h01, 1'b1);
    check_regs("tp_busywr");

    // Asynchronous reset in the middle of a run
    set_reg(4'h6, 8'h35);
    got_w.delete();
    got_t.delete();
    wr(4'hF, 8'h01);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", bus.we, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_data", bus.data, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_nwords", got_w.size(), 2);
    rst_n = 1'b1;
    m_x = '0; m_y = '0; m_addr = '0; m_auto = '0;
    @(negedge clk);
    check_regs("mid_rst");

    // Randomized commands
    for (int it = 0; it < 60; it++) begin
      xr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 340));
      yr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
      set_reg(4'h6, 8'($urandom));
      set16(4'h8, xr);
      set16(4'hA, yr);
      set16(4'hC, 16'($urandom));
      ca = ($urandom_range(0, 1) == 0) ? 4'hE : 4'hF;
      run_cmd("rnd", ca, 8'($urandom), 1'($urandom_range(0, 3) == 0));
      check_regs("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
